// File: rtl/ifetch_prefetch_buf.sv
// ifetch_prefetch_buf: instruction-fetch front end with an in-order prefetch FIFO.
// Issues credit-limited requests to a variable-latency instruction memory, tags
// each request with its PC, and queues returned words with PC/PC+4 for decode.
// Redirects flush the buffer and discard responses that are still in flight.
// Optional build macro IFETCH_STATS_EN adds saturating redirect/drop/bubble counters.
module ifetch_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h20,
    parameter logic [7:0]  HALT_PC  = 8'hF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [7:0]  pc_out,
    output logic [7:0]  pc4_out,
    output logic        busy
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0] stat_redirects,
    output logic [15:0] stat_dropped,
    output logic [15:0] stat_bubbles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic { RUN, HALT } state_t;

    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
    localparam cnt_t        FULL_C  = cnt_t'(DEPTH);

    state_t      state_q, state_d;
    logic [7:0]  fetch_pc;

    logic [31:0] fifo_inst [DEPTH];
    logic [7:0]  fifo_pc   [DEPTH];
    logic [7:0]  fifo_pc4  [DEPTH];
    ptr_t        rd_ptr, wr_ptr;
    cnt_t        fifo_count;

    logic [7:0]  tag_q [DEPTH];
    ptr_t        tag_rd, tag_wr;

    // outstanding counts live (kept) requests only; stale ones move into drop_cnt
    cnt_t        outstanding;
    logic [7:0]  drop_cnt;

    logic [CW:0] credit_used;
    logic        grant, resp_keep, resp_drop, pop;

    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req    = !rst && pc_en && (state_q == RUN) && !redirect &&
                         (fetch_pc < HALT_PC) && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign resp_keep   = imem_rvalid && !redirect && (drop_cnt == '0);
    assign resp_drop   = imem_rvalid && (redirect || (drop_cnt != '0));
    assign inst_valid  = (fifo_count != '0);
    assign pop         = inst_valid && !id_stall && pc_en && !redirect;
    assign inst_out    = fifo_inst[rd_ptr];
    assign pc_out      = fifo_pc[rd_ptr];
    assign pc4_out     = fifo_pc4[rd_ptr];
    assign busy        = (outstanding != '0) || (drop_cnt != '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next-state: halt once fetch_pc crosses HALT_PC, resume on an in-range redirect
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!redirect && pc_en && (fetch_pc >= HALT_PC)) state_d = HALT;
            HALT:    if (redirect && (redirect_pc < HALT_PC)) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Fetch PC, tag queue, prefetch FIFO and in-flight accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
                fifo_pc4[i]  <= '0;
                tag_q[i]     <= '0;
            end
        end else if (redirect) begin
            // every live request becomes stale; a response landing now is already discarded
            fetch_pc    <= redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + 8'(outstanding) - 8'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc      <= fetch_pc + 8'd4;
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= tag_wr + ptr_t'(1);
            end
            if (resp_keep) begin
                fifo_inst[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]   <= tag_q[tag_rd];
                fifo_pc4[wr_ptr]  <= tag_q[tag_rd] + 8'd4;
                wr_ptr            <= wr_ptr + ptr_t'(1);
                tag_rd            <= tag_rd + ptr_t'(1);
            end
            if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
            if (resp_keep && !pop)      fifo_count <= fifo_count + cnt_t'(1);
            else if (!resp_keep && pop) fifo_count <= fifo_count - cnt_t'(1);
            outstanding <= outstanding + cnt_t'(grant) - cnt_t'(resp_keep);
            if (resp_drop) drop_cnt <= drop_cnt - 8'd1;
        end
    end

    // Credit rule guarantees a kept response always finds room
    always_ff @(posedge clk) begin
        if (!rst) assert (!(resp_keep && !pop && (fifo_count == FULL_C)));
    end

`ifdef IFETCH_STATS_EN
    // Saturating activity counters, frozen while halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_redirects <= '0;
            stat_dropped   <= '0;
            stat_bubbles   <= '0;
        end else if (state_q == RUN) begin
            if (redirect && (stat_redirects != '1))
                stat_redirects <= stat_redirects + 16'd1;
            if (resp_drop && (stat_dropped != '1))
                stat_dropped <= stat_dropped + 16'd1;
            if (pc_en && !inst_valid && !id_stall && (stat_bubbles != '1))
                stat_bubbles <= stat_bubbles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// tb_ifetch_prefetch_buf: directed bench for the fetch prefetch buffer with an
// in-order, configurable-latency memory model. Each memory word is
// {8'hA5, addr, ~addr, 8'h5A}.
module tb_ifetch_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        id_stall;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [7:0]  pc_out;
    logic [7:0]  pc4_out;
    logic        busy;
`ifdef IFETCH_STATS_EN
    logic [15:0] stat_redirects, stat_dropped, stat_bubbles;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;
    logic [7:0] q_addr[$];
    int         q_due[$];

    always #5 clk = ~clk;

    ifetch_prefetch_buf #(.DEPTH(4), .RESET_PC(8'h20), .HALT_PC(8'hF0)) dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_stall(id_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out),
        .pc4_out(pc4_out), .busy(busy)
`ifdef IFETCH_STATS_EN
        , .stat_redirects(stat_redirects), .stat_dropped(stat_dropped),
        .stat_bubbles(stat_bubbles)
`endif
    );

    function automatic logic [31:0] word(input logic [7:0] a);
        return {8'hA5, a, ~a, 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake mid-cycle, then update the memory model
    task automatic tick();
        logic       fire;
        logic [7:0] a;
        int         due;
        @(negedge clk);
        fire = imem_req && imem_gnt;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (fire) begin
            due = cyc + lat;
            if (q_due.size() > 0 && due <= q_due[$]) due = q_due[$] + 1;
            q_addr.push_back(a);
            q_due.push_back(due);
        end
        cyc++;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        id_stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        q_addr.delete(); q_due.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, with pc_en high to show reset gates the request
        rst = 1'b1; pc_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
        id_stall = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        #2;
        chk("rst_req",   imem_req,   0);
        chk("rst_addr",  imem_addr,  8'h20);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst",  inst_out,   0);
        chk("rst_pc",    pc_out,     0);
        chk("rst_pc4",   pc4_out,    0);
        chk("rst_busy",  busy,       0);

        // T1: latency 1, streaming
        do_reset(); lat = 1; pc_en = 1; imem_gnt = 1;
        #1; chk("t1_req_c0", imem_req, 1); chk("t1_addr_c0", imem_addr, 8'h20);
        tick(); #1; chk("t1_valid_c1", inst_valid, 0);
        tick(); #1; chk("t1_valid_c2", inst_valid, 1); chk("t1_pc_c2", pc_out, 8'h20);
        chk("t1_pc4_c2", pc4_out, 8'h24); chk("t1_inst_c2", inst_out, 32'hA520DF5A);
        tick(); #1; chk("t1_valid_c3", inst_valid, 1); chk("t1_pc_c3", pc_out, 8'h24); chk("t1_pc4_c3", pc4_out, 8'h28);
        tick(); #1; chk("t1_valid_c4", inst_valid, 1); chk("t1_pc_c4", pc_out, 8'h28); chk("t1_pc4_c4", pc4_out, 8'h2C);
        tick(); #1; chk("t1_valid_c5", inst_valid, 1); chk("t1_pc_c5", pc_out, 8'h2C); chk("t1_pc4_c5", pc4_out, 8'h30);

        // T2: decode stall fills the FIFO, then drains with no gap
        do_reset(); lat = 1; pc_en = 1; imem_gnt = 1; id_stall = 1;
        repeat (4) tick();
        for (int i = 4; i < 10; i++) begin
            #1;
            chk($sformatf("t2_req_c%0d", i), imem_req, 0);
            chk($sformatf("t2_valid_c%0d", i), inst_valid, 1);
            chk($sformatf("t2_pc_c%0d", i), pc_out, 8'h20);
            if (i == 5) chk("t2_addr_c5", imem_addr, 8'h30);
            tick();
        end
        id_stall = 0;
        #1; chk("t2_req_c10", imem_req, 0);
        chk("t2_valid_c10", inst_valid, 1); chk("t2_pc_c10", pc_out, 8'h20);
        tick(); #1; chk("t2_req_c11", imem_req, 1);
        chk("t2_valid_c11", inst_valid, 1); chk("t2_pc_c11", pc_out, 8'h24);
        tick(); #1; chk("t2_valid_c12", inst_valid, 1); chk("t2_pc_c12", pc_out, 8'h28);
        tick(); #1; chk("t2_valid_c13", inst_valid, 1); chk("t2_pc_c13", pc_out, 8'h2C);
        tick(); #1; chk("t2_valid_c14", inst_valid, 1); chk("t2_pc_c14", pc_out, 8'h30);

        // T3: latency 4, redirect with 3 live requests in flight
        do_reset(); lat = 4; pc_en = 1; imem_gnt = 1;
        repeat (3) tick();
        redirect = 1; redirect_pc = 8'h40;
        #1; chk("t3_req_redirect", imem_req, 0);
        tick(); redirect = 0;
        #1; chk("t3_req_c4", imem_req, 1); chk("t3_addr_c4", imem_addr, 8'h40);
        for (int i = 4; i < 8; i++) begin
            if (i > 4) #1;
            chk($sformatf("t3_valid_c%0d", i), inst_valid, 0);
            chk($sformatf("t3_busy_c%0d", i), busy, 1);
            tick();
        end
        #1; chk("t3_valid_c8", inst_valid, 0); chk("t3_req_c8", imem_req, 0);
        tick(); #1; chk("t3_valid_c9", inst_valid, 1); chk("t3_pc_c9", pc_out, 8'h40);
        chk("t3_inst_c9", inst_out, 32'hA540BF5A);

        // T4: redirect in the same cycle as a response, 2 in flight
        do_reset(); lat = 2; pc_en = 1; imem_gnt = 1;
        repeat (2) tick();
        redirect = 1; redirect_pc = 8'h60;
        tick(); redirect = 0;
        #1; chk("t4_valid_c3", inst_valid, 0); chk("t4_addr_c3", imem_addr, 8'h60);
        tick(); #1; chk("t4_valid_c4", inst_valid, 0);
        tick(); #1; chk("t4_valid_c5", inst_valid, 0);
        tick(); #1; chk("t4_valid_c6", inst_valid, 1); chk("t4_pc_c6", pc_out, 8'h60);
        chk("t4_inst_c6", inst_out, 32'hA5609F5A);
        tick(); #1; chk("t4_pc_c7", pc_out, 8'h64);

        // T5: grant withheld for 5 cycles
        do_reset(); lat = 1; pc_en = 1; imem_gnt = 1;
        tick(); imem_gnt = 0;
        for (int i = 1; i < 6; i++) begin
            #1;
            chk($sformatf("t5_req_c%0d", i), imem_req, 1);
            chk($sformatf("t5_addr_c%0d", i), imem_addr, 8'h24);
            if (i == 2) chk("t5_pc_c2", pc_out, 8'h20);
            chk($sformatf("t5_valid_c%0d", i), inst_valid, (i == 2) ? 1 : 0);
            tick();
        end
        imem_gnt = 1;
        #1; chk("t5_addr_c6", imem_addr, 8'h24);
        tick(); tick(); #1;
        chk("t5_valid_c8", inst_valid, 1); chk("t5_pc_c8", pc_out, 8'h24);
        chk("t5_inst_c8", inst_out, 32'hA524DB5A);
        tick(); #1; chk("t5_pc_c9", pc_out, 8'h28);

        // T6: run into HALT_PC, drain, then resume by redirect
        do_reset(); lat = 1; pc_en = 1; imem_gnt = 1;
        redirect = 1; redirect_pc = 8'hE8;
        #1; chk("t6_req_c0", imem_req, 0);
        tick(); redirect = 0;
        #1; chk("t6_req_c1", imem_req, 1); chk("t6_addr_c1", imem_addr, 8'hE8);
        tick(); #1; chk("t6_addr_c2", imem_addr, 8'hEC);
        tick(); #1; chk("t6_req_c3", imem_req, 0); chk("t6_pc_c3", pc_out, 8'hE8);
        tick(); #1; chk("t6_req_c4", imem_req, 0); chk("t6_pc_c4", pc_out, 8'hEC);
        chk("t6_pc4_c4", pc4_out, 8'hF0);
        tick(); #1; chk("t6_valid_c5", inst_valid, 0); chk("t6_busy_c5", busy, 0);
        chk("t6_req_c5", imem_req, 0);
        tick(); redirect = 1; redirect_pc = 8'h30;
        tick(); redirect = 0;
        #1; chk("t6_req_c7", imem_req, 1); chk("t6_addr_c7", imem_addr, 8'h30);
        tick(); tick(); #1;
        chk("t6_valid_c9", inst_valid, 1); chk("t6_pc_c9", pc_out, 8'h30);
        chk("t6_pc4_c9", pc4_out, 8'h34);
`ifdef IFETCH_STATS_EN
        chk("t6_stat_redirects", stat_redirects, 1);
`endif

        // T7: pc_en low blocks issue and freezes fetch_pc
        do_reset(); lat = 1; pc_en = 0; imem_gnt = 1;
        #1; chk("t7_req_c0", imem_req, 0);
        tick(); #1; chk("t7_addr_c1", imem_addr, 8'h20); chk("t7_busy_c1", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
